// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port bundle: CPU load/store path, DMA path and the shared memory port.
// slave = arbiter side, master = environment (pipeline, DMA engine, memory).
interface dmem_port_arbiter_if #(
  parameter int AW  = 8,
  parameter int DW  = 32,
  parameter int BEW = 4
);
  logic           cpu_req;
  logic           cpu_we;
  logic [AW-1:0]  cpu_addr;
  logic [BEW-1:0] cpu_byteena;
  logic [DW-1:0]  cpu_wdata;
  logic           cpu_stall;
  logic [DW-1:0]  cpu_rdata;
  logic           cpu_rvalid;

  logic           dma_req;
  logic           dma_we;
  logic [AW-1:0]  dma_addr;
  logic [BEW-1:0] dma_byteena;
  logic [DW-1:0]  dma_wdata;
  logic           dma_gnt;
  logic [DW-1:0]  dma_rdata;
  logic           dma_rvalid;

  logic [AW-1:0]  mem_addr;
  logic           mem_we;
  logic [BEW-1:0] mem_byteena;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_byteena, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_byteena, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_we, mem_byteena, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_byteena, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_byteena, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_we, mem_byteena, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: CPU first, DMA promoted
// after MAX_WAIT ungranted cycles; one-cycle read latency routed back by owner tag.
module dmem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int BEW      = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  dmem_port_arbiter_if.slave  bus
);
  typedef struct packed {
    logic           we;
    logic [AW-1:0]  addr;
    logic [BEW-1:0] byteena;
    logic [DW-1:0]  wdata;
  } req_t;

  typedef enum logic {IDLE = 1'b0, CPU_LOAD_RESP = 1'b1} state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic          rd_vld;
  logic          rd_owner;   // 1 = in-flight read belongs to DMA
  logic [AW-1:0] last_addr;

  req_t cpu_r, dma_r, win_r;
  logic cpu_elig, dma_pri, cpu_win, dma_win, issue;

  assign cpu_r = '{we: bus.cpu_we, addr: bus.cpu_addr, byteena: bus.cpu_byteena, wdata: bus.cpu_wdata};
  assign dma_r = '{we: bus.dma_we, addr: bus.dma_addr, byteena: bus.dma_byteena, wdata: bus.dma_wdata};

  always_comb begin
    cpu_elig = bus.cpu_req & (state == IDLE);
    dma_pri  = (wait_cnt == 4'(MAX_WAIT));
    cpu_win  = ~reset & cpu_elig & ~(bus.dma_req & dma_pri);
    dma_win  = ~reset & bus.dma_req & ~cpu_win;
    issue    = cpu_win | dma_win;
    win_r    = dma_win ? dma_r : cpu_r;
  end

  // Idle port keeps the last address to avoid needless address toggling.
  assign bus.mem_we      = issue & win_r.we;
  assign bus.mem_addr    = reset ? '0 : (issue ? win_r.addr : last_addr);
  assign bus.mem_byteena = issue ? win_r.byteena : '0;
  assign bus.mem_wdata   = issue ? win_r.wdata : '0;

  assign bus.cpu_stall  = cpu_elig & ~reset & ~(cpu_win & bus.cpu_we);
  assign bus.dma_gnt    = dma_win;
  assign bus.cpu_rvalid = ~reset & rd_vld & ~rd_owner;
  assign bus.dma_rvalid = ~reset & rd_vld & rd_owner;
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rd_vld    <= 1'b0;
      rd_owner  <= 1'b0;
      last_addr <= '0;
    end else begin
      case (state)
        IDLE:          if (cpu_win & ~bus.cpu_we) state <= CPU_LOAD_RESP;
        CPU_LOAD_RESP: state <= IDLE;
        default:       state <= IDLE;
      endcase
      rd_vld   <= issue & ~win_r.we;
      rd_owner <= dma_win;
      if (issue) last_addr <= win_r.addr;
      if (dma_win)
        wait_cnt <= '0;
      else if (bus.dma_req && !dma_pri)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed test-plan sequences followed by a randomized run, all checked against
// a cycle-level reference model of the arbitration rules and a shadow memory.
module tb_dmem_port_arbiter;
  localparam int AW = 8, DW = 32, BEW = 4, MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;

  dmem_port_arbiter_if #(.AW(AW), .DW(DW), .BEW(BEW)) bus ();

  dmem_port_arbiter #(.AW(AW), .DW(DW), .BEW(BEW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    if (a == 'h10) return 32'hDEADBEEF;
    if (a == 'h20) return 32'hCAFEF00D;
    return (32'(a) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Environment memory: synchronous read, byte-enabled write.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we)
        for (int b = 0; b < BEW; b++)
          if (bus.mem_byteena[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:255];
  int          wcnt;
  bit          load_due;
  int          pend_kind;   // 0 none, 1 CPU read data due, 2 DMA read data due
  logic [31:0] pend_data;
  logic [7:0]  last_addr;
  bit          last_stall, last_gnt;
  int          nvec, nerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int win;
    bit cpu_elig, exp_stall;
    logic [7:0] a;
    win = 0;
    exp_stall = 0;
    @(negedge clk);
    if (reset) begin
      chk("rst_stall", bus.cpu_stall, 0);
      chk("rst_gnt", bus.dma_gnt, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
      chk("rst_dma_rvalid", bus.dma_rvalid, 0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 0);
      chk("rst_dma_rdata", bus.dma_rdata, 0);
    end else begin
      cpu_elig = bus.cpu_req && !load_due;
      if (cpu_elig && !(bus.dma_req && wcnt == MAX_WAIT)) win = 1;
      else if (bus.dma_req) win = 2;
      exp_stall = cpu_elig && !(win == 1 && bus.cpu_we);
      chk("cpu_stall", bus.cpu_stall, exp_stall);
      chk("dma_gnt", bus.dma_gnt, win == 2);
      chk("mem_we", bus.mem_we, (win == 1) ? bus.cpu_we : (win == 2) ? bus.dma_we : 1'b0);
      chk("mem_addr", bus.mem_addr, (win == 1) ? bus.cpu_addr : (win == 2) ? bus.dma_addr : last_addr);
      if (win != 0) begin
        chk("mem_byteena", bus.mem_byteena, (win == 1) ? bus.cpu_byteena : bus.dma_byteena);
        chk("mem_wdata", bus.mem_wdata, (win == 1) ? bus.cpu_wdata : bus.dma_wdata);
      end
      chk("cpu_rvalid", bus.cpu_rvalid, pend_kind == 1);
      chk("dma_rvalid", bus.dma_rvalid, pend_kind == 2);
      if (pend_kind == 1) chk("cpu_rdata", bus.cpu_rdata, pend_data);
      if (pend_kind == 2) chk("dma_rdata", bus.dma_rdata, pend_data);
    end
    @(posedge clk);
    last_stall = exp_stall;
    last_gnt   = (win == 2);
    if (reset) begin
      wcnt = 0; load_due = 0; pend_kind = 0; last_addr = '0;
    end else begin
      pend_kind = 0;
      load_due  = (win == 1) && !bus.cpu_we;
      if (win != 0) begin
        a = (win == 1) ? bus.cpu_addr : bus.dma_addr;
        last_addr = a;
        if ((win == 1) ? bus.cpu_we : bus.dma_we) begin
          for (int b = 0; b < BEW; b++)
            if ((win == 1) ? bus.cpu_byteena[b] : bus.dma_byteena[b])
              ref_mem[a][8*b +: 8] = (win == 1) ? bus.cpu_wdata[8*b +: 8] : bus.dma_wdata[8*b +: 8];
        end else begin
          pend_kind = win;
          pend_data = ref_mem[a];
        end
      end
      if (win == 2) wcnt = 0;
      else if (bus.dma_req && wcnt < MAX_WAIT) wcnt++;
    end
    #1;
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [7:0] a,
                         input logic [3:0] be, input logic [31:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_byteena = be; bus.cpu_wdata = d;
  endtask

  task automatic set_dma(input bit req, input bit we, input logic [7:0] a,
                         input logic [3:0] be, input logic [31:0] d);
    bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_byteena = be; bus.dma_wdata = d;
  endtask

  initial begin
    nvec = 0; nerr = 0;
    wcnt = 0; load_due = 0; pend_kind = 0; pend_data = '0; last_addr = '0;
    last_stall = 0; last_gnt = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    reset = 1'b1; mem_init = 1'b1;
    set_cpu(0, 0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);
    #1;
    cycle();
    mem_init = 1'b0;
    cycle();
    reset = 1'b0;

    // CPU load 0x10 with DMA idle
    set_cpu(1, 0, 8'h10, 4'hF, 0);
    cycle();
    cycle();
    set_cpu(0, 0, 0, 0, 0);
    cycle();

    // Back-to-back CPU stores with a DMA write held: DMA promoted on the 5th
    set_dma(1, 1, 8'h33, 4'hF, 32'hAAAA5555);
    set_cpu(1, 1, 8'h05, 4'hF, 32'h12345678);
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_gnt) set_dma(0, 0, 0, 0, 0);
      if (!last_stall) set_cpu(1, 1, 8'(8'h06 + i), 4'(4'h3 << (i % 3)), $urandom);
    end
    set_cpu(0, 0, 0, 0, 0);
    cycle();

    // CPU load overlapping a pending DMA read of 0x20
    set_dma(1, 0, 8'h20, 4'hF, 0);
    set_cpu(1, 0, 8'h40, 4'hF, 0);
    cycle();
    cycle();
    set_dma(0, 0, 0, 0, 0);
    set_cpu(0, 0, 0, 0, 0);
    cycle();

    // Reset landing on the response cycle of a load, then a fresh load
    set_cpu(1, 0, 8'h10, 4'hF, 0);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    cycle();
    set_cpu(0, 0, 0, 0, 0);

    // DMA-only write stream
    for (int i = 0; i < 3; i++) begin
      set_dma(1, 1, 8'(8'h50 + i), 4'hF, $urandom);
      cycle();
    end
    set_dma(0, 0, 0, 0, 0);
    cycle();

    // Randomized traffic over a small address window to force collisions
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!last_stall)
        set_cpu($urandom_range(0, 9) < 6, $urandom_range(0, 1), 8'($urandom_range(0, 15)),
                4'($urandom_range(1, 15)), $urandom);
      if (!(bus.dma_req && !last_gnt))
        set_dma($urandom_range(0, 9) < 5, $urandom_range(0, 1), 8'($urandom_range(0, 15)),
                4'($urandom_range(1, 15)), $urandom);
      cycle();
    end
    reset = 1'b0;
    set_cpu(0, 0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
